uart_cfg_ctrl: RTL and testbench

//  Framed UART command controller that configures the analyzer's 24-bit frequency threshold.

---
 rtl/uart_cfg_ctrl.sv | 273 +++++++++++++++++++++++++++
 tb/tb_uart_cfg_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg_ctrl.sv
// Purpose : framed UART command parser that owns the analyzer's 24-bit frequency threshold.
// Latency : a new value lands in freq_threshold one edge after the CHK byte when cfg_hold is low.
// Backpr. : cfg_hold defers applies indefinitely (last accepted value wins); rx bytes are never stalled.
//
// Frame: A5, CMD, P2, P1, P0, CHK where CHK = CMD^P2^P1^P0 and payload = {P2,P1,P0}.
//   CMD 01 set threshold, CMD 02 preset (P0+1)*10000, CMD 03 sweep (only with CFG_SWEEP_EN).
// Optional feature macro: CFG_SWEEP_EN (automatic threshold sweep; also adds SWEEP_PERIOD).
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   rx_valid, rx_byte      one-cycle byte strobe from the serial receiver
//   cfg_hold               consumer busy: defer threshold changes
//   freq_threshold         applied threshold (Hz)
//   cfg_update             one-cycle pulse on each apply (even if the value is unchanged)
//   frame_err, err_code    reject pulse; code 1=checksum 2=cmd/range 3=timeout, held until next error
//   sweep_active           sweep running (constant 0 when the sweep feature is not built)
module uart_cfg_ctrl #(
    parameter int unsigned THR_DEFAULT  = 10000,
    parameter int unsigned THR_MIN      = 10000,
    parameter int unsigned THR_MAX      = 2000000,
`ifdef CFG_SWEEP_EN
    parameter int unsigned SWEEP_PERIOD = 5000000,
`endif
    parameter int unsigned TIMEOUT_CYC  = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    input  logic        cfg_hold,
    output logic [23:0] freq_threshold,
    output logic        cfg_update,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        sweep_active
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_PL2,
        ST_PL1,
        ST_PL0,
        ST_CHK
    } state_t;

    localparam logic [7:0]  HDR_BYTE    = 8'hA5;
    localparam logic [7:0]  CMD_SET     = 8'h01;
    localparam logic [7:0]  CMD_PRESET  = 8'h02;
    localparam logic [1:0]  ERR_CHK     = 2'd1;
    localparam logic [1:0]  ERR_CMD     = 2'd2;
    localparam logic [1:0]  ERR_TO      = 2'd3;
    localparam logic [23:0] THR_MIN_V   = 24'(THR_MIN);
    localparam logic [23:0] THR_MAX_V   = 24'(THR_MAX);
    localparam logic [23:0] THR_RST_V   = 24'(THR_DEFAULT);
    localparam logic [23:0] PRESET_UNIT = 24'd10000;
    localparam int unsigned TO_W        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_t          state_q, state_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [7:0]      p2_q, p2_d;
    logic [7:0]      p1_q, p1_d;
    logic [7:0]      p0_q, p0_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [23:0]     pend_q, pend_d;
    logic            pend_vld_q, pend_vld_d;
    logic [23:0]     thr_q, thr_d;
    logic            upd_q, upd_d;
    logic            ferr_q, ferr_d;
    logic [1:0]      err_q, err_d;

    logic [23:0]     payload;
    logic            chk_ok;
    logic            cmd_ok;
    logic [23:0]     cmd_val;

`ifdef CFG_SWEEP_EN
    localparam int unsigned PER_W          = $clog2(SWEEP_PERIOD + 1);
    localparam logic [PER_W-1:0] PER_LAST  = PER_W'(SWEEP_PERIOD - 1);
    localparam logic [23:0] STEP_MAX       = 24'(THR_MAX - THR_MIN);
    localparam logic [7:0]  CMD_SWEEP      = 8'h03;

    logic             sweep_q, sweep_d;
    logic [23:0]      step_q, step_d;
    logic [PER_W-1:0] per_q, per_d;
    logic             cmd_sweep;
    logic [24:0]      sweep_sum;
    logic [23:0]      sweep_next;

    // One bit of headroom so the wrap test sees sums above THR_MAX.
    assign sweep_sum  = {1'b0, thr_q} + {1'b0, step_q};
    assign sweep_next = (sweep_sum > {1'b0, THR_MAX_V}) ? THR_MIN_V : sweep_sum[23:0];
`endif

    assign payload = {p2_q, p1_q, p0_q};
    assign chk_ok  = ((cmd_q ^ p2_q ^ p1_q ^ p0_q) == rx_byte);

    // Command decode on the registered frame; only consulted on the CHK byte.
    always_comb begin
        cmd_ok  = 1'b0;
        cmd_val = payload;
`ifdef CFG_SWEEP_EN
        cmd_sweep = 1'b0;
`endif
        case (cmd_q)
            CMD_SET: begin
                cmd_ok = (payload >= THR_MIN_V) && (payload <= THR_MAX_V);
            end
            CMD_PRESET: begin
                cmd_ok  = (p2_q == 8'd0) && (p1_q == 8'd0) && (p0_q <= 8'd9);
                cmd_val = (24'(p0_q) + 24'd1) * PRESET_UNIT;
            end
`ifdef CFG_SWEEP_EN
            CMD_SWEEP: begin
                cmd_ok    = (payload >= 24'd1) && (payload <= STEP_MAX);
                cmd_val   = THR_MIN_V;
                cmd_sweep = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Priority, lowest to highest: apply, sweep tick, frame parse. A frame
    // accepted on the same edge as an apply therefore re-arms pend_vld while
    // the apply consumes the previous pend value.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        p2_d       = p2_q;
        p1_d       = p1_q;
        p0_d       = p0_q;
        to_cnt_d   = to_cnt_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        thr_d      = thr_q;
        upd_d      = 1'b0;
        ferr_d     = 1'b0;
        err_d      = err_q;
`ifdef CFG_SWEEP_EN
        sweep_d    = sweep_q;
        step_d     = step_q;
        per_d      = per_q;
`endif

        if (pend_vld_q && !cfg_hold) begin
            thr_d      = pend_q;
            pend_vld_d = 1'b0;
            upd_d      = 1'b1;
        end

`ifdef CFG_SWEEP_EN
        // The period counter only runs while the consumer accepts changes.
        if (sweep_q && !cfg_hold) begin
            if (per_q == PER_LAST) begin
                per_d      = '0;
                pend_d     = sweep_next;
                pend_vld_d = 1'b1;
            end else begin
                per_d = per_q + 1'b1;
            end
        end
`endif

        if (rx_valid) begin
            // A byte on the timeout edge wins over the timeout.
            to_cnt_d = '0;
            case (state_q)
                ST_IDLE: if (rx_byte == HDR_BYTE) state_d = ST_CMD;
                ST_CMD: begin
                    cmd_d   = rx_byte;
                    state_d = ST_PL2;
                end
                ST_PL2: begin
                    p2_d    = rx_byte;
                    state_d = ST_PL1;
                end
                ST_PL1: begin
                    p1_d    = rx_byte;
                    state_d = ST_PL0;
                end
                ST_PL0: begin
                    p0_d    = rx_byte;
                    state_d = ST_CHK;
                end
                ST_CHK: begin
                    state_d = ST_IDLE;
                    if (!chk_ok) begin
                        ferr_d = 1'b1;
                        err_d  = ERR_CHK;
                    end else if (!cmd_ok) begin
                        ferr_d = 1'b1;
                        err_d  = ERR_CMD;
                    end else begin
                        pend_d     = cmd_val;
                        pend_vld_d = 1'b1;
`ifdef CFG_SWEEP_EN
                        sweep_d = cmd_sweep;
                        if (cmd_sweep) begin
                            step_d = payload;
                            per_d  = '0;
                        end
`endif
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (to_cnt_q == TO_LAST) begin
                state_d  = ST_IDLE;
                to_cnt_d = '0;
                ferr_d   = 1'b1;
                err_d    = ERR_TO;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cmd_q      <= 8'd0;
            p2_q       <= 8'd0;
            p1_q       <= 8'd0;
            p0_q       <= 8'd0;
            to_cnt_q   <= '0;
            pend_q     <= 24'd0;
            pend_vld_q <= 1'b0;
            thr_q      <= THR_RST_V;
            upd_q      <= 1'b0;
            ferr_q     <= 1'b0;
            err_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            p2_q       <= p2_d;
            p1_q       <= p1_d;
            p0_q       <= p0_d;
            to_cnt_q   <= to_cnt_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            thr_q      <= thr_d;
            upd_q      <= upd_d;
            ferr_q     <= ferr_d;
            err_q      <= err_d;
        end
    end

`ifdef CFG_SWEEP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_q <= 1'b0;
            step_q  <= 24'd0;
            per_q   <= '0;
        end else begin
            sweep_q <= sweep_d;
            step_q  <= step_d;
            per_q   <= per_d;
        end
    end

    assign sweep_active = sweep_q;
`else
    assign sweep_active = 1'b0;
`endif

    assign freq_threshold = thr_q;
    assign cfg_update     = upd_q;
    assign frame_err      = ferr_q;
    assign err_code       = err_q;

endmodule

// File: tb/tb_uart_cfg_ctrl.sv
`timescale 1ns/1ps
module tb_uart_cfg_ctrl;

    localparam int unsigned TO_CYC = 40;
`ifdef CFG_SWEEP_EN
    localparam int unsigned SW_PER = 100;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        cfg_hold;
    logic [23:0] freq_threshold;
    logic        cfg_update;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        sweep_active;

    int checks   = 0;
    int failures = 0;
    int n_upd    = 0;
    int n_ferr   = 0;

    uart_cfg_ctrl #(
        .THR_DEFAULT (10000),
        .THR_MIN     (10000),
        .THR_MAX     (2000000),
`ifdef CFG_SWEEP_EN
        .SWEEP_PERIOD(SW_PER),
`endif
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_valid      (rx_valid),
        .rx_byte       (rx_byte),
        .cfg_hold      (cfg_hold),
        .freq_threshold(freq_threshold),
        .cfg_update    (cfg_update),
        .frame_err     (frame_err),
        .err_code      (err_code),
        .sweep_active  (sweep_active)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled on the falling edge.
    always @(negedge clk) begin
        if (cfg_update) n_upd++;
        if (frame_err)  n_ferr++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [23:0] pay, input bit good, input int gap);
        logic [7:0] b [6];
        b[0] = 8'hA5;
        b[1] = cmd;
        b[2] = pay[23:16];
        b[3] = pay[15:8];
        b[4] = pay[7:0];
        b[5] = cmd ^ pay[23:16] ^ pay[15:8] ^ pay[7:0] ^ (good ? 8'h00 : 8'h01);
        for (int i = 0; i < 6; i++) begin
            send_byte(b[i]);
            if (gap > 0) idle($urandom_range(gap, 0));
        end
    endtask

    // Frame-level reference: what a complete frame should do, from the command rules.
    function automatic void ref_frame(input int cmd, input int pay, input bit good,
                                      output bit acc, output int val, output int code);
        acc  = 1'b0;
        val  = 0;
        code = 0;
        if (!good) code = 1;
        else if (cmd == 1 && pay >= 10000 && pay <= 2000000) begin
            acc = 1'b1;
            val = pay;
        end else if (cmd == 2 && pay >= 0 && pay <= 9) begin
            acc = 1'b1;
            val = (pay + 1) * 10000;
        end else code = 2;
    endfunction

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] pay;
        bit          good;
        int          exp_thr;
        int          exp_err;
        int          exp_upd;
        int          exp_ferr;
    } vec_t;

    vec_t vt [15];

    initial begin
        int b_upd, b_ferr;
        int exp_thr, exp_err;

        vt[0]  = '{8'h01, 24'h00C350, 1'b1,   50000, 1, 1, 0};
        vt[0].exp_err = 0;
        vt[1]  = '{8'h02, 24'h000004, 1'b1,   50000, 0, 1, 0};
        vt[2]  = '{8'h02, 24'h000004, 1'b0,   50000, 1, 0, 1};
        vt[3]  = '{8'h01, 24'h1E8481, 1'b1,   50000, 2, 0, 1};
        vt[4]  = '{8'h01, 24'h1E8480, 1'b1, 2000000, 2, 1, 0};
        vt[5]  = '{8'h01, 24'h00270F, 1'b1, 2000000, 2, 0, 1};
        vt[6]  = '{8'h01, 24'h002710, 1'b1,   10000, 2, 1, 0};
        vt[7]  = '{8'h02, 24'h000009, 1'b1,  100000, 2, 1, 0};
        vt[8]  = '{8'h02, 24'h00000A, 1'b1,  100000, 2, 0, 1};
        vt[9]  = '{8'h02, 24'h010000, 1'b1,  100000, 2, 0, 1};
        vt[10] = '{8'h04, 24'h000001, 1'b0,  100000, 1, 0, 1};
        vt[11] = '{8'h04, 24'h000001, 1'b1,  100000, 2, 0, 1};
        vt[12] = '{8'h01, 24'h00A5A5, 1'b1,   42405, 2, 1, 0};
        vt[13] = '{8'h02, 24'h000000, 1'b1,   10000, 2, 1, 0};
        vt[14] = '{8'h00, 24'h000000, 1'b1,   10000, 2, 0, 1};

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        cfg_hold = 1'b0;
        idle(3);
        check("rst_thr",   int'(freq_threshold), 10000);
        check("rst_upd",   int'(cfg_update),     0);
        check("rst_ferr",  int'(frame_err),      0);
        check("rst_err",   int'(err_code),       0);
        check("rst_sweep", int'(sweep_active),   0);
        rst_n = 1'b1;
        idle(2);
        check("post_rst_thr", int'(freq_threshold), 10000);

        // Table-driven frames.
        for (int i = 0; i < 15; i++) begin
            b_upd  = n_upd;
            b_ferr = n_ferr;
            send_frame(vt[i].cmd, vt[i].pay, vt[i].good, 2);
            idle(4);
            check($sformatf("vec%0d_thr", i),  int'(freq_threshold), vt[i].exp_thr);
            check($sformatf("vec%0d_err", i),  int'(err_code),       vt[i].exp_err);
            check($sformatf("vec%0d_upd", i),  n_upd - b_upd,        vt[i].exp_upd);
            check($sformatf("vec%0d_ferr", i), n_ferr - b_ferr,      vt[i].exp_ferr);
        end

        // Apply latency: threshold and cfg_update change one edge after CHK.
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hC3); send_byte(8'h50); send_byte(8'h92);
        check("lat_thr_e0", int'(freq_threshold), 10000);
        check("lat_upd_e0", int'(cfg_update),     0);
        idle(1);
        check("lat_thr_e1", int'(freq_threshold), 50000);
        check("lat_upd_e1", int'(cfg_update),     1);
        idle(1);
        check("lat_upd_e2", int'(cfg_update),     0);

        // Rejected frame pulse timing.
        send_frame(8'h02, 24'h000004, 1'b0, 0);
        check("rej_ferr_e0", int'(frame_err), 1);
        check("rej_err",     int'(err_code),  1);
        idle(1);
        check("rej_ferr_e1", int'(frame_err),      0);
        check("rej_thr",     int'(freq_threshold), 50000);

        // Timeout after PL1 stall.
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'hC3);
        b_ferr = n_ferr;
        idle(TO_CYC - 2);
        check("to_early_ferr", n_ferr - b_ferr, 0);
        check("to_early_err",  int'(err_code),  1);
        idle(4);
        check("to_ferr", n_ferr - b_ferr, 1);
        check("to_err",  int'(err_code),  3);
        b_upd = n_upd;
        send_frame(8'h01, 24'h0186A0, 1'b1, 0);
        idle(4);
        check("to_recover_thr", int'(freq_threshold), 100000);
        check("to_recover_upd", n_upd - b_upd,        1);

        // Bytes arriving just inside the timeout keep the frame alive.
        b_ferr = n_ferr;
        send_byte(8'hA5); idle(TO_CYC - 3);
        send_byte(8'h01); idle(TO_CYC - 3);
        send_byte(8'h03); idle(TO_CYC - 3);
        send_byte(8'h0D); idle(TO_CYC - 3);
        send_byte(8'h40); idle(TO_CYC - 3);
        send_byte(8'h01 ^ 8'h03 ^ 8'h0D ^ 8'h40);
        idle(4);
        check("slow_ferr", n_ferr - b_ferr, 0);
        check("slow_thr",  int'(freq_threshold), 200000);

        // Hold: two accepted frames, one apply with the last value.
        cfg_hold = 1'b1;
        b_upd    = n_upd;
        send_frame(8'h01, 24'h007530, 1'b1, 1);
        send_frame(8'h01, 24'h009C40, 1'b1, 1);
        idle(10);
        check("hold_upd", n_upd - b_upd,        0);
        check("hold_thr", int'(freq_threshold), 200000);
        cfg_hold = 1'b0;
        idle(4);
        check("release_upd", n_upd - b_upd,        1);
        check("release_thr", int'(freq_threshold), 40000);

        // Accept and apply on the same edge: old pend applied, new one follows.
        cfg_hold = 1'b1;
        send_frame(8'h01, 24'h0124F8, 1'b1, 0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
        send_byte(8'h38); send_byte(8'h80);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = 8'h01 ^ 8'h01 ^ 8'h38 ^ 8'h80;
        cfg_hold = 1'b0;
        @(negedge clk);
        rx_valid = 1'b0;
        check("coinc_thr_e0", int'(freq_threshold), 75000);
        check("coinc_upd_e0", int'(cfg_update),     1);
        idle(1);
        check("coinc_thr_e1", int'(freq_threshold), 80000);
        check("coinc_upd_e1", int'(cfg_update),     1);
        idle(1);
        check("coinc_upd_e2", int'(cfg_update),     0);

        // Reset drops a pending update and a partial frame.
        cfg_hold = 1'b1;
        send_frame(8'h01, 24'h0493E0, 1'b1, 0);
        send_byte(8'hA5); send_byte(8'h01);
        @(negedge clk);
        rst_n = 1'b0;
        idle(2);
        rst_n    = 1'b1;
        cfg_hold = 1'b0;
        b_upd    = n_upd;
        b_ferr   = n_ferr;
        idle(5);
        check("rst_pend_thr", int'(freq_threshold), 10000);
        check("rst_pend_upd", n_upd - b_upd,        0);
        send_byte(8'h00); send_byte(8'hC3); send_byte(8'h50); send_byte(8'h92);
        idle(TO_CYC + 5);
        check("rst_tail_thr",  int'(freq_threshold), 10000);
        check("rst_tail_ferr", n_ferr - b_ferr,      0);
        check("rst_tail_err",  int'(err_code),       0);
        exp_thr = 10000;
        exp_err = 0;

`ifndef CFG_SWEEP_EN
        send_frame(8'h03, 24'h0F4240, 1'b1, 0);
        idle(4);
        check("sweep_off_err",   int'(err_code),     2);
        check("sweep_off_state", int'(sweep_active), 0);
        exp_err = 2;
`endif

        // Randomized frames against the frame-level reference.
        for (int n = 0; n < 40; n++) begin
            logic [7:0]  cmd;
            logic [23:0] pay;
            bit          good, acc;
            int          val, code, sel;
            sel = int'($urandom_range(3, 0));
            if (sel == 1) begin
                cmd = 8'h02;
                pay = 24'($urandom_range(12, 0));
                if ($urandom_range(3, 0) == 0) pay = pay | 24'h000100;
            end else if (sel == 2) begin
                cmd = 8'($urandom_range(255, 0));
                if (cmd == 8'h03) cmd = 8'h04;
                pay = 24'($urandom_range(2100000, 0));
            end else begin
                cmd = 8'h01;
                case ($urandom_range(5, 0))
                    0:       pay = 24'd9999;
                    1:       pay = 24'd10000;
                    2:       pay = 24'd2000000;
                    3:       pay = 24'd2000001;
                    default: pay = 24'($urandom_range(2100000, 0));
                endcase
            end
            good = ($urandom_range(3, 0) != 0);
            ref_frame(int'(cmd), int'(pay), good, acc, val, code);
            b_upd  = n_upd;
            b_ferr = n_ferr;
            send_frame(cmd, pay, good, 3);
            idle(4);
            if (acc) exp_thr = val;
            else     exp_err = code;
            check($sformatf("rnd%0d_thr", n),  int'(freq_threshold), exp_thr);
            check($sformatf("rnd%0d_err", n),  int'(err_code),       exp_err);
            check($sformatf("rnd%0d_upd", n),  n_upd - b_upd,        acc ? 1 : 0);
            check($sformatf("rnd%0d_ferr", n), n_ferr - b_ferr,      acc ? 0 : 1);
        end

`ifdef CFG_SWEEP_EN
        // Sweep: illegal step, then 1000000 steps with wrap, then stop by a set frame.
        send_frame(8'h03, 24'h000000, 1'b1, 0);
        idle(4);
        check("sweep_step0_err",   int'(err_code),     2);
        check("sweep_step0_state", int'(sweep_active), 0);
        send_frame(8'h03, 24'h0F4240, 1'b1, 0);
        check("sweep_active", int'(sweep_active), 1);
        idle(50);
        check("sweep_s0", int'(freq_threshold), 10000);
        idle(SW_PER);
        check("sweep_s1", int'(freq_threshold), 1010000);
        idle(SW_PER);
        check("sweep_s2_wrap", int'(freq_threshold), 10000);
        idle(SW_PER);
        check("sweep_s3", int'(freq_threshold), 1010000);
        send_frame(8'h01, 24'h00C350, 1'b1, 0);
        idle(4);
        check("sweep_stop_state", int'(sweep_active),   0);
        check("sweep_stop_thr",   int'(freq_threshold), 50000);
        idle(SW_PER + 10);
        check("sweep_stopped_thr", int'(freq_threshold), 50000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
